// File: rtl/rename_free_list.sv
// Physical-register free list for rename: speculative and committed free vectors,
// all-or-nothing multi-lane allocation (lowest index first), single-cycle flush restore.
module rename_free_list #(
    parameter int NUM_PREGS = 48,
    parameter int RESERVED  = 32,
    parameter int ALLOC_W   = 4,
    parameter int CMT_W     = 4,
    parameter int PBITS     = $clog2(NUM_PREGS),
    parameter int ABITS     = $clog2(NUM_PREGS + 1),
    parameter int CBITS     = $clog2(ALLOC_W + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [CBITS-1:0]         i_alloc_count,
    output logic                     o_alloc_valid,
    output logic                     o_alloc_fail,
    output logic [CBITS-1:0]         o_alloc_count,
    output logic [ALLOC_W*PBITS-1:0] o_alloc_p,
    input  logic [CMT_W-1:0]         i_cmt_valid,
    input  logic [CMT_W*PBITS-1:0]   i_cmt_new_p,
    input  logic [CMT_W*PBITS-1:0]   i_cmt_old_p,
    input  logic                     i_flush,
    output logic [ABITS-1:0]         o_avail_count,
    output logic                     o_double_free
);

    localparam logic [NUM_PREGS-1:0] FREE_INIT = {NUM_PREGS{1'b1}} << RESERVED;

    logic [NUM_PREGS-1:0]     spec_free_q, spec_free_d;
    logic [NUM_PREGS-1:0]     cmt_free_q, cmt_free_d;
    logic                     alloc_valid_q, alloc_valid_d;
    logic                     alloc_fail_q, alloc_fail_d;
    logic [CBITS-1:0]         alloc_count_q, alloc_count_d;
    logic [ALLOC_W*PBITS-1:0] alloc_p_q, alloc_p_d;
    logic [ABITS-1:0]         avail_q, avail_d;
    logic                     dbl_q, dbl_d;

    logic [NUM_PREGS-1:0]     freed_mask;
    logic                     dbl_hit;
    logic [PBITS-1:0]         lane_old, lane_new;
    logic [NUM_PREGS-1:0]     chain, low_bit, sel_mask;
    logic [ALLOC_W*PBITS-1:0] sel_p;
    logic                     req_ok;

    function automatic logic [PBITS-1:0] onehot_to_bin(input logic [NUM_PREGS-1:0] oh);
        logic [PBITS-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < NUM_PREGS; i++) begin
            if (oh[i]) b = b | PBITS'(i);
        end
        return b;
    endfunction

    // Commit lanes: double free is judged against the pre-commit speculative vector
    // and against tags already freed by earlier lanes in the same cycle.
    always_comb begin
        cmt_free_d = cmt_free_q;
        freed_mask = '0;
        dbl_hit    = 1'b0;
        lane_old   = '0;
        lane_new   = '0;
        for (int unsigned l = 0; l < CMT_W; l++) begin
            if (i_cmt_valid[l]) begin
                lane_old = i_cmt_old_p[l*PBITS +: PBITS];
                lane_new = i_cmt_new_p[l*PBITS +: PBITS];
                cmt_free_d[lane_new] = 1'b0;
                cmt_free_d[lane_old] = 1'b1;
                if (spec_free_q[lane_old] || freed_mask[lane_old]) dbl_hit = 1'b1;
                freed_mask[lane_old] = 1'b1;
            end
        end
    end

    // Clear-lowest-bit chain over the pre-commit speculative vector (no bypass).
    always_comb begin
        chain    = spec_free_q;
        low_bit  = '0;
        sel_mask = '0;
        sel_p    = '0;
        for (int unsigned k = 0; k < ALLOC_W; k++) begin
            low_bit = chain & (~chain + NUM_PREGS'(1));
            if (k < 32'(i_alloc_count)) begin
                sel_mask                  = sel_mask | low_bit;
                sel_p[k*PBITS +: PBITS]   = onehot_to_bin(low_bit);
            end
            chain = chain & (chain - NUM_PREGS'(1));
        end
    end

    assign req_ok = (i_alloc_count <= CBITS'(ALLOC_W)) &&
                    (ABITS'(i_alloc_count) <= avail_q);

    always_comb begin
        spec_free_d   = spec_free_q | freed_mask;
        alloc_valid_d = 1'b0;
        alloc_fail_d  = 1'b0;
        alloc_count_d = '0;
        alloc_p_d     = '0;
        dbl_d         = dbl_q | dbl_hit;
        if (i_flush) begin
            spec_free_d = cmt_free_d;
        end else if (i_alloc_count != '0) begin
            if (req_ok) begin
                alloc_valid_d = 1'b1;
                alloc_count_d = i_alloc_count;
                alloc_p_d     = sel_p;
                spec_free_d   = spec_free_d & ~sel_mask;
            end else begin
                alloc_fail_d  = 1'b1;
            end
        end
        avail_d = '0;
        for (int unsigned i = 0; i < NUM_PREGS; i++) begin
            avail_d = avail_d + ABITS'(spec_free_d[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            spec_free_q   <= FREE_INIT;
            cmt_free_q    <= FREE_INIT;
            alloc_valid_q <= 1'b0;
            alloc_fail_q  <= 1'b0;
            alloc_count_q <= '0;
            alloc_p_q     <= '0;
            avail_q       <= ABITS'(NUM_PREGS - RESERVED);
            dbl_q         <= 1'b0;
        end else begin
            spec_free_q   <= spec_free_d;
            cmt_free_q    <= cmt_free_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_fail_q  <= alloc_fail_d;
            alloc_count_q <= alloc_count_d;
            alloc_p_q     <= alloc_p_d;
            avail_q       <= avail_d;
            dbl_q         <= dbl_d;
        end
    end

    assign o_alloc_valid = alloc_valid_q;
    assign o_alloc_fail  = alloc_fail_q;
    assign o_alloc_count = alloc_count_q;
    assign o_alloc_p     = alloc_p_q;
    assign o_avail_count = avail_q;
    assign o_double_free = dbl_q;

endmodule

// File: tb/tb_rename_free_list.sv
// Directed bench for rename_free_list: allocation, exhaustion, no-bypass, flush, double free.
module tb_rename_free_list;

    localparam int NUM_PREGS = 48;
    localparam int ALLOC_W   = 4;
    localparam int CMT_W     = 4;
    localparam int PBITS     = 6;
    localparam int ABITS     = 6;
    localparam int CBITS     = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [CBITS-1:0]         alloc_count;
    logic                     alloc_valid, alloc_fail;
    logic [CBITS-1:0]         alloc_count_o;
    logic [ALLOC_W*PBITS-1:0] alloc_p;
    logic [CMT_W-1:0]         cmt_valid;
    logic [CMT_W*PBITS-1:0]   cmt_new_p, cmt_old_p;
    logic                     flush;
    logic [ABITS-1:0]         avail;
    logic                     dbl;

    int n_cmp = 0;
    int n_err = 0;

    rename_free_list #(
        .NUM_PREGS(NUM_PREGS), .RESERVED(32), .ALLOC_W(ALLOC_W), .CMT_W(CMT_W)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_alloc_count(alloc_count),
        .o_alloc_valid(alloc_valid), .o_alloc_fail(alloc_fail),
        .o_alloc_count(alloc_count_o), .o_alloc_p(alloc_p),
        .i_cmt_valid(cmt_valid), .i_cmt_new_p(cmt_new_p), .i_cmt_old_p(cmt_old_p),
        .i_flush(flush), .o_avail_count(avail), .o_double_free(dbl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [ALLOC_W*PBITS-1:0] tags(input int a, input int b, input int c, input int d);
        return {PBITS'(d), PBITS'(c), PBITS'(b), PBITS'(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_count = '0;
        cmt_valid   = '0;
        cmt_new_p   = '0;
        cmt_old_p   = '0;
        flush       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic commit0(input int new_p, input int old_p);
        cmt_valid = 4'b0001;
        cmt_new_p = '0;
        cmt_old_p = '0;
        cmt_new_p[PBITS-1:0] = PBITS'(new_p);
        cmt_old_p[PBITS-1:0] = PBITS'(old_p);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();

        // Reset state and first grant
        do_reset();
        check("rst_valid", 64'(alloc_valid), 64'd0);
        check("rst_fail",  64'(alloc_fail), 64'd0);
        check("rst_count", 64'(alloc_count_o), 64'd0);
        check("rst_p",     64'(alloc_p), 64'd0);
        check("rst_avail", 64'(avail), 64'd16);
        check("rst_dbl",   64'(dbl), 64'd0);
        alloc_count = 3'd4; step();
        check("g1_valid", 64'(alloc_valid), 64'd1);
        check("g1_fail",  64'(alloc_fail), 64'd0);
        check("g1_count", 64'(alloc_count_o), 64'd4);
        check("g1_p",     64'(alloc_p), 64'(tags(32, 33, 34, 35)));
        check("g1_avail", 64'(avail), 64'd12);

        // Exhaustion
        step();
        check("g2_p", 64'(alloc_p), 64'(tags(36, 37, 38, 39)));
        step();
        step();
        check("g4_p",     64'(alloc_p), 64'(tags(44, 45, 46, 47)));
        check("g4_avail", 64'(avail), 64'd0);
        alloc_count = 3'd1; step();
        check("ex_fail",  64'(alloc_fail), 64'd1);
        check("ex_valid", 64'(alloc_valid), 64'd0);
        check("ex_count", 64'(alloc_count_o), 64'd0);
        check("ex_p",     64'(alloc_p), 64'd0);
        check("ex_avail", 64'(avail), 64'd0);

        // No bypass: freed tag only grantable next cycle
        commit0(32, 5); step();
        check("nb_fail",  64'(alloc_fail), 64'd1);
        check("nb_avail", 64'(avail), 64'd1);
        check("nb_dbl",   64'(dbl), 64'd0);
        idle_inputs(); alloc_count = 3'd1; step();
        check("nb_valid", 64'(alloc_valid), 64'd1);
        check("nb_count", 64'(alloc_count_o), 64'd1);
        check("nb_p",     64'(alloc_p), 64'(tags(5, 0, 0, 0)));
        check("nb_avail2", 64'(avail), 64'd0);

        // Flush restores committed view
        do_reset();
        alloc_count = 3'd4; step(); step();
        check("fl_avail8", 64'(avail), 64'd8);
        idle_inputs(); commit0(32, 3); step();
        check("fl_cmt_avail", 64'(avail), 64'd9);
        idle_inputs(); flush = 1'b1; step();
        check("fl_avail", 64'(avail), 64'd16);
        check("fl_valid", 64'(alloc_valid), 64'd0);
        idle_inputs(); alloc_count = 3'd2; step();
        check("fl_p",     64'(alloc_p), 64'(tags(3, 33, 0, 0)));
        check("fl_count", 64'(alloc_count_o), 64'd2);
        check("fl_avail14", 64'(avail), 64'd14);

        // Flush with concurrent commit and request
        do_reset();
        alloc_count = 3'd4; step();
        idle_inputs(); flush = 1'b1; alloc_count = 3'd2; commit0(32, 7); step();
        check("fc_valid", 64'(alloc_valid), 64'd0);
        check("fc_fail",  64'(alloc_fail), 64'd0);
        check("fc_avail", 64'(avail), 64'd16);
        check("fc_dbl",   64'(dbl), 64'd0);
        idle_inputs(); alloc_count = 3'd4; step();
        check("fc_p",     64'(alloc_p), 64'(tags(7, 33, 34, 35)));
        check("fc_avail12", 64'(avail), 64'd12);

        // Double free of an already-free tag; sticky until reset
        idle_inputs(); commit0(41, 40); step();
        check("df_flag",  64'(dbl), 64'd1);
        check("df_avail", 64'(avail), 64'd12);
        idle_inputs();
        for (int i = 0; i < 10; i++) step();
        check("df_sticky", 64'(dbl), 64'd1);
        check("df_avail2", 64'(avail), 64'd12);
        rst = 1'b1; step(); rst = 1'b0;
        check("df_rst", 64'(dbl), 64'd0);

        // Two lanes freeing the same busy tag
        step();
        cmt_valid = 4'b0011;
        cmt_new_p = '0; cmt_old_p = '0;
        cmt_new_p[PBITS-1:0] = 6'd32; cmt_new_p[2*PBITS-1:PBITS] = 6'd33;
        cmt_old_p[PBITS-1:0] = 6'd5;  cmt_old_p[2*PBITS-1:PBITS] = 6'd5;
        step();
        check("dl_flag",  64'(dbl), 64'd1);
        check("dl_avail", 64'(avail), 64'd17);

        // Oversized request fails
        do_reset();
        alloc_count = 3'd5; step();
        check("ov_fail",  64'(alloc_fail), 64'd1);
        check("ov_valid", 64'(alloc_valid), 64'd0);
        check("ov_avail", 64'(avail), 64'd16);

        // Reset discards an in-flight request
        alloc_count = 3'd4; rst = 1'b1; step(); rst = 1'b0;
        idle_inputs();
        check("mr_valid", 64'(alloc_valid), 64'd0);
        check("mr_p",     64'(alloc_p), 64'd0);
        check("mr_avail", 64'(avail), 64'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
